// File: rtl/fds_sst_ctrl.sv
// fds_sst_ctrl -- save-state sequencer for the sound unit.
//
// Sweeps the sound unit's save-state register window [ADDR_FIRST, ADDR_LAST]
// and either streams every register out to the host (save) or writes a host
// byte stream back into it (load). The sound unit is held in save-state mode
// (sst_act) for the whole transfer.
//
// Ports
//   clk, rst_n            block clock, asynchronous active-low reset
//   cmd_save / cmd_load   one-cycle start requests (honoured only in IDLE)
//   cmd_abort             end the running transfer early
//   out_data/out_valid/out_ready   byte stream to host (save)
//   in_data/in_valid/in_ready      byte stream from host (load)
//   sst_act, sst_addr, sst_dato, sst_we_reg, ss_rdat   sound-unit save-state port
//   busy, done, aborted   transfer status
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for cmd_save / cmd_load
// S_SETTLE | sst_addr just changed; capture ss_rdat into out_data
// S_OUT    | out_data offered to host, waiting for out_ready
// L_WAIT   | in_ready high, waiting for a host byte
// L_WR     | one-cycle write strobe to the sound unit
// FINISH   | one-cycle done pulse, release save-state mode
module fds_sst_ctrl #(
    parameter int ADDR_FIRST = 16,
    parameter int ADDR_LAST  = 123
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_save,
    input  logic       cmd_load,
    input  logic       cmd_abort,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       sst_act,
    output logic [7:0] sst_addr,
    output logic [7:0] sst_dato,
    output logic       sst_we_reg,
    input  logic [7:0] ss_rdat,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        S_SETTLE = 3'd1,
        S_OUT    = 3'd2,
        L_WAIT   = 3'd3,
        L_WR     = 3'd4,
        FINISH   = 3'd5
    } state_t;

    localparam logic [7:0] A_FIRST = 8'(ADDR_FIRST);
    localparam logic [7:0] A_LAST  = 8'(ADDR_LAST);

    state_t     state_q, state_d;
    logic       sst_act_q, sst_act_d;
    logic [7:0] sst_addr_q, sst_addr_d;
    logic [7:0] sst_dato_q, sst_dato_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       aborted_q, aborted_d;
    // Abort that arrived together with a load handshake: the accepted byte is
    // still written, then the sweep ends instead of advancing.
    logic       abort_pend_q, abort_pend_d;

    logic       at_last;

    // The compare against A_LAST (rather than an overflow test) is what stops
    // the sweep, so an ADDR_LAST of 255 never wraps to 0.
    assign at_last = (sst_addr_q == A_LAST);

    always_comb begin
        state_d      = state_q;
        sst_act_d    = sst_act_q;
        sst_addr_d   = sst_addr_q;
        sst_dato_d   = sst_dato_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        aborted_d    = aborted_q;
        abort_pend_d = abort_pend_q;

        unique case (state_q)
            IDLE: begin
                abort_pend_d = 1'b0;
                if (cmd_save || cmd_load) begin
                    state_d    = cmd_save ? S_SETTLE : L_WAIT;
                    sst_addr_d = A_FIRST;
                    sst_act_d  = 1'b1;
                    aborted_d  = 1'b0;
                end
            end
            S_SETTLE: begin
                if (cmd_abort) begin
                    state_d   = FINISH;
                    aborted_d = 1'b1;
                end else begin
                    out_data_d  = ss_rdat;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end
            end
            S_OUT: begin
                if (cmd_abort) begin
                    aborted_d = 1'b1;
                end
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (at_last || cmd_abort) begin
                        state_d = FINISH;
                    end else begin
                        sst_addr_d = sst_addr_q + 8'd1;
                        state_d    = S_SETTLE;
                    end
                end else if (cmd_abort) begin
                    // Withdraw the unaccepted byte so the host cannot take it
                    // during FINISH.
                    out_valid_d = 1'b0;
                    state_d     = FINISH;
                end
            end
            L_WAIT: begin
                if (cmd_abort) begin
                    aborted_d = 1'b1;
                end
                if (in_valid) begin
                    sst_dato_d   = in_data;
                    abort_pend_d = cmd_abort;
                    state_d      = L_WR;
                end else if (cmd_abort) begin
                    state_d = FINISH;
                end
            end
            L_WR: begin
                abort_pend_d = 1'b0;
                if (cmd_abort) begin
                    aborted_d = 1'b1;
                end
                if (at_last || abort_pend_q || cmd_abort) begin
                    state_d = FINISH;
                end else begin
                    sst_addr_d = sst_addr_q + 8'd1;
                    state_d    = L_WAIT;
                end
            end
            FINISH: begin
                sst_act_d   = 1'b0;
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                sst_act_d   = 1'b0;
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sst_act_q    <= 1'b0;
            sst_addr_q   <= 8'd0;
            sst_dato_q   <= 8'd0;
            out_data_q   <= 8'd0;
            out_valid_q  <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sst_act_q    <= sst_act_d;
            sst_addr_q   <= sst_addr_d;
            sst_dato_q   <= sst_dato_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            aborted_q    <= aborted_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    // Pure decodes of the state register, so reset clears them immediately.
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FINISH);
    assign in_ready   = (state_q == L_WAIT);
    assign sst_we_reg = (state_q == L_WR);

    assign sst_act   = sst_act_q;
    assign sst_addr  = sst_addr_q;
    assign sst_dato  = sst_dato_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_fds_sst_ctrl.sv
module tb_fds_sst_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, cmd_save, cmd_load, cmd_abort, out_ready, in_valid;
    logic [7:0] in_data, ss_rdat, out_data, sst_addr, sst_dato;
    logic       out_valid, in_ready, sst_act, sst_we_reg, busy, done, aborted;

    logic       cmd_save_h, tie0;
    logic [7:0] ss_rdat_h, out_data_h, sst_addr_h, sst_dato_h;
    logic       out_valid_h, in_ready_h, sst_act_h, sst_we_reg_h, busy_h, done_h, aborted_h;

    logic [7:0] mem [256];
    logic [7:0] ld  [256];
    bit         xor_mode;

    // Sound-unit model: combinational read of the register window.
    assign ss_rdat   = xor_mode ? (sst_addr ^ 8'h5A) : mem[sst_addr];
    assign ss_rdat_h = mem[sst_addr_h];

    fds_sst_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_save(cmd_save), .cmd_load(cmd_load), .cmd_abort(cmd_abort),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sst_act(sst_act), .sst_addr(sst_addr), .sst_dato(sst_dato), .sst_we_reg(sst_we_reg),
        .ss_rdat(ss_rdat), .busy(busy), .done(done), .aborted(aborted)
    );

    fds_sst_ctrl #(.ADDR_FIRST(255), .ADDR_LAST(255)) dut_hi (
        .clk(clk), .rst_n(rst_n), .cmd_save(cmd_save_h), .cmd_load(tie0), .cmd_abort(tie0),
        .out_data(out_data_h), .out_valid(out_valid_h), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_h),
        .sst_act(sst_act_h), .sst_addr(sst_addr_h), .sst_dato(sst_dato_h), .sst_we_reg(sst_we_reg_h),
        .ss_rdat(ss_rdat_h), .busy(busy_h), .done(done_h), .aborted(aborted_h)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  out_q[$];
    logic [7:0]  out_qh[$];
    logic [15:0] wr_q[$];
    int busy_cnt, busy_cnt_h, done_cnt, inr_cnt, act_err, stab_err, hi_zero_err;
    bit         prev_stall;
    logic [7:0] prev_data;

    // Bus observer, sampled mid-cycle: a handshake seen here completes at the
    // following rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) out_q.push_back(out_data);
            if (sst_we_reg) wr_q.push_back({sst_addr, sst_dato});
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (in_ready) inr_cnt++;
            if (sst_act !== busy) act_err++;
            if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) stab_err++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid_h && out_ready) out_qh.push_back(out_data_h);
            if (busy_h) busy_cnt_h++;
            if (sst_act_h && sst_addr_h == 8'd0) hi_zero_err++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_obs();
        out_q.delete(); out_qh.delete(); wr_q.delete();
        busy_cnt = 0; busy_cnt_h = 0; done_cnt = 0; inr_cnt = 0;
        act_err = 0; stab_err = 0; hi_zero_err = 0;
    endtask

    task automatic pulse_cmd(input bit save, input bit load);
        @(posedge clk); #1 cmd_save = save; cmd_load = load;
        @(posedge clk); #1 cmd_save = 1'b0; cmd_load = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int t;
        t = 0;
        while (done !== 1'b1 && t < limit) begin @(negedge clk); t++; end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, t);
        end
        @(negedge clk); #1;
    endtask

    // Host side of a save: accept n bytes with random back-pressure; the byte
    // at stall_idx is held off for 5 cycles; abort rides on handshake abort_at.
    task automatic drive_save(input int n, input int abort_at, input int stall_idx);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            do begin @(negedge clk); t++; end while (out_valid !== 1'b1 && t < 50);
            vectors++;
            if (out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL save_wait byte %0d: out_valid=%b, required 1", i, out_valid);
                return;
            end
            repeat ((i == stall_idx) ? 4 : int'($urandom_range(0, 2))) @(posedge clk);
            @(posedge clk); #1 out_ready = 1'b1; cmd_abort = (i == abort_at);
            @(posedge clk); #1 out_ready = 1'b0; cmd_abort = 1'b0;
        end
    endtask

    // Host side of a load: offer ld[0..n-1] with random gaps; abort rides on
    // handshake abort_at.
    task automatic drive_load(input int n, input int abort_at, input int max_gap);
        for (int k = 0; k < n; k++) begin
            int t;
            t = 0;
            do begin @(negedge clk); t++; end while (in_ready !== 1'b1 && t < 50);
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL load_wait byte %0d: in_ready=%b, required 1", k, in_ready);
                return;
            end
            repeat ($urandom_range(0, max_gap)) @(posedge clk);
            @(posedge clk); #1 in_valid = 1'b1; in_data = ld[k]; cmd_abort = (k == abort_at);
            @(posedge clk); #1 in_valid = 1'b0; cmd_abort = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [30:0] st;
        st = {sst_act, sst_we_reg, busy, done, in_ready, out_valid, aborted, sst_addr, sst_dato, out_data};
        vectors++;
        if (st !== '0) begin
            miscompares++;
            $display("FAIL reset_held: outputs=%h, required 0", st);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        st = {sst_act, sst_we_reg, busy, done, in_ready, out_valid, aborted, sst_addr, sst_dato, out_data};
        vectors++;
        if (st !== '0) begin
            miscompares++;
            $display("FAIL reset_released_idle: outputs=%h, required 0", st);
        end
    endtask

    task automatic test_save_xor();
        logic [7:0] exp_q[$];
        int bad;
        clear_obs(); xor_mode = 1'b1;
        @(posedge clk); #1 out_ready = 1'b1;
        pulse_cmd(1'b1, 1'b0);
        wait_done(400);
        out_ready = 1'b0;
        for (int a = 16; a <= 123; a++) exp_q.push_back(8'(a) ^ 8'h5A);
        bad = (out_q.size() != exp_q.size()) ? 0 : -1;
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            if (bad < 0 && out_q[i] !== exp_q[i]) bad = i;
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL save_xor_stream: %0d bytes, first bad idx %0d got %h, required %0d bytes %h",
                     out_q.size(), bad, (bad < out_q.size()) ? out_q[bad] : 8'h00, exp_q.size(), exp_q[bad]);
        end
        vectors++;
        if (busy_cnt != 217) begin miscompares++; $display("FAIL save_xor_busy: %0d cycles, required 217", busy_cnt); end
        vectors++;
        if (done_cnt != 1 || aborted !== 1'b0) begin
            miscompares++;
            $display("FAIL save_xor_status: done pulses %0d aborted %b, required 1 and 0", done_cnt, aborted);
        end
        vectors++;
        if (act_err != 0) begin miscompares++; $display("FAIL save_xor_act: %0d sst_act/busy disagreements, required 0", act_err); end
        xor_mode = 1'b0;
    endtask

    task automatic test_load_gaps();
        int bad;
        clear_obs();
        for (int k = 0; k < 256; k++) ld[k] = 8'(k);
        pulse_cmd(1'b0, 1'b1);
        drive_load(108, -1, 3);
        wait_done(50);
        bad = (wr_q.size() != 108) ? 0 : -1;
        for (int k = 0; k < 108 && k < wr_q.size(); k++)
            if (bad < 0 && wr_q[k] !== {8'(16 + k), 8'(k)}) bad = k;
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL load_writes: %0d writes, first bad idx %0d got %h, required 108 writes %h",
                     wr_q.size(), bad, (bad < wr_q.size()) ? wr_q[bad] : 16'h0, {8'(16 + bad), 8'(bad)});
        end
        vectors++;
        if (act_err != 0 || done_cnt != 1 || aborted !== 1'b0) begin
            miscompares++;
            $display("FAIL load_status: act_err %0d done %0d aborted %b, required 0 1 0", act_err, done_cnt, aborted);
        end
    endtask

    task automatic test_save_stall();
        int bad;
        clear_obs();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[20] = 8'hFF;
        pulse_cmd(1'b1, 1'b0);
        drive_save(108, -1, 3);
        wait_done(50);
        bad = (out_q.size() != 108) ? 0 : -1;
        for (int i = 0; i < 108 && i < out_q.size(); i++)
            if (bad < 0 && out_q[i] !== mem[16 + i]) bad = i;
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL stall_stream: %0d bytes, first bad idx %0d got %h, required 108 bytes %h",
                     out_q.size(), bad, (bad < out_q.size()) ? out_q[bad] : 8'h00, mem[16 + bad]);
        end
        vectors++;
        if (stab_err != 0) begin miscompares++; $display("FAIL stall_stable: %0d unstable stall cycles, required 0", stab_err); end
    endtask

    task automatic test_abort_load();
        clear_obs();
        for (int k = 0; k < 256; k++) ld[k] = 8'($urandom);
        pulse_cmd(1'b0, 1'b1);
        drive_load(10, 9, 2);
        @(negedge clk);
        vectors++;
        if (sst_we_reg !== 1'b1) begin miscompares++; $display("FAIL abort_last_write: sst_we_reg=%b, required 1", sst_we_reg); end
        @(negedge clk);
        vectors++;
        if ({done, aborted, in_ready} !== 3'b110) begin
            miscompares++;
            $display("FAIL abort_finish: done/aborted/in_ready=%b, required 110", {done, aborted, in_ready});
        end
        @(negedge clk); #1;
        vectors++;
        if (wr_q.size() != 10 || wr_q[9] !== {8'd25, ld[9]} || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_writes: %0d writes busy %b, required 10 writes ending %h, busy 0",
                     wr_q.size(), busy, {8'd25, ld[9]});
        end
    endtask

    task automatic test_priority();
        int bad;
        clear_obs();
        @(posedge clk); #1 out_ready = 1'b1;
        pulse_cmd(1'b1, 1'b1);
        repeat (20) @(posedge clk);
        #1 cmd_load = 1'b1;
        @(posedge clk); #1 cmd_load = 1'b0;
        wait_done(400);
        out_ready = 1'b0;
        bad = (out_q.size() != 108) ? 0 : -1;
        for (int i = 0; i < 108 && i < out_q.size(); i++)
            if (bad < 0 && out_q[i] !== mem[16 + i]) bad = i;
        vectors++;
        if (bad >= 0) begin miscompares++; $display("FAIL prio_stream: %0d bytes, first bad idx %0d, required 108 matching", out_q.size(), bad); end
        vectors++;
        if (wr_q.size() != 0 || inr_cnt != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_no_load: writes %0d in_ready cycles %0d busy %b, required 0 0 0", wr_q.size(), inr_cnt, busy);
        end
    endtask

    task automatic test_random_xfer();
        for (int it = 0; it < 4; it++) begin
            bit is_save;
            int m, ab, bad;
            is_save = 1'($urandom_range(0, 1));
            m  = $urandom_range(1, 108);
            ab = (m == 108) ? -1 : m - 1;
            clear_obs();
            for (int i = 0; i < 256; i++) begin mem[i] = 8'($urandom); ld[i] = 8'($urandom); end
            pulse_cmd(is_save, !is_save);
            if (is_save) drive_save(m, ab, -1);
            else         drive_load(m, ab, 2);
            wait_done(50);
            bad = -1;
            if (is_save) begin
                if (out_q.size() != m) bad = 0;
                for (int i = 0; i < m && i < out_q.size(); i++)
                    if (bad < 0 && out_q[i] !== mem[16 + i]) bad = i;
            end else begin
                if (wr_q.size() != m) bad = 0;
                for (int i = 0; i < m && i < wr_q.size(); i++)
                    if (bad < 0 && wr_q[i] !== {8'(16 + i), ld[i]}) bad = i;
            end
            vectors++;
            if (bad >= 0) begin
                miscompares++;
                $display("FAIL rand_xfer it%0d save=%0d: %0d items, first bad idx %0d, required %0d matching",
                         it, is_save, is_save ? out_q.size() : wr_q.size(), bad, m);
            end
            vectors++;
            if (aborted !== (ab >= 0) || done_cnt != 1 || act_err != 0) begin
                miscompares++;
                $display("FAIL rand_status it%0d: aborted %b done %0d act_err %0d, required %b 1 0",
                         it, aborted, done_cnt, act_err, (ab >= 0));
            end
        end
    endtask

    task automatic test_single_255();
        int t;
        clear_obs();
        mem[255] = 8'($urandom);
        mem[0]   = ~mem[255];
        @(posedge clk); #1 cmd_save_h = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 cmd_save_h = 1'b0;
        t = 0;
        while (done_h !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        @(negedge clk); #1;
        out_ready = 1'b0;
        vectors++;
        if (out_qh.size() != 1 || out_qh[0] !== mem[255]) begin
            miscompares++;
            $display("FAIL hi_stream: %0d bytes first %h, required 1 byte %h",
                     out_qh.size(), (out_qh.size() > 0) ? out_qh[0] : 8'h00, mem[255]);
        end
        vectors++;
        if (hi_zero_err != 0 || busy_cnt_h != 3 || sst_act_h !== 1'b0) begin
            miscompares++;
            $display("FAIL hi_bounds: addr0 hits %0d busy %0d act %b, required 0 3 0", hi_zero_err, busy_cnt_h, sst_act_h);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [30:0] st;
        clear_obs();
        pulse_cmd(1'b0, 1'b1);
        drive_load(3, -1, 1);
        #2 rst_n = 1'b0;
        #1;
        st = {sst_act, sst_we_reg, busy, done, in_ready, out_valid, aborted, sst_addr, sst_dato, out_data};
        vectors++;
        if (st !== '0) begin miscompares++; $display("FAIL midreset_outputs: %h, required 0", st); end
        repeat (2) @(posedge clk);
        @(negedge clk); #1 rst_n = 1'b1; cmd_save = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 cmd_save = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, sst_act, done_cnt == 0} !== 3'b111) begin
            miscompares++;
            $display("FAIL first_edge_accept: busy %b act %b done pulses %0d, required 1 1 0", busy, sst_act, done_cnt);
        end
        wait_done(400);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_save = 1'b0; cmd_load = 1'b0; cmd_abort = 1'b0;
        out_ready = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        cmd_save_h = 1'b0; tie0 = 1'b0; xor_mode = 1'b0;
        for (int i = 0; i < 256; i++) begin mem[i] = 8'($urandom); ld[i] = 8'(i); end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_save_xor();
        test_load_gaps();
        test_save_stall();
        test_abort_load();
        test_priority();
        test_random_xfer();
        test_single_255();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fds_sst_ctrl.md
FDS_SST_CTRL -- requirements
Module: fds_sst_ctrl

Interface
REQ-001 Parameter ADDR_FIRST, default 16, first save-state register address swept.
REQ-002 Parameter ADDR_LAST, default 123, last save-state register address swept (inclusive); ADDR_FIRST <= ADDR_LAST <= 255.
REQ-003 clk  in  1  single block clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 cmd_save  in  1  one-cycle request: stream sound-unit state out.
REQ-006 cmd_load  in  1  one-cycle request: stream sound-unit state in.
REQ-007 cmd_abort  in  1  terminate the current transfer.
REQ-008 out_data  out  8  saved byte; out_valid  out  1; out_ready  in  1  (valid/ready byte stream to host).
REQ-009 in_data  in  8  byte to restore; in_valid  in  1; in_ready  out  1  (valid/ready byte stream from host).
REQ-010 sst_act  out  1  holds the sound unit in save-state mode.
REQ-011 sst_addr  out  8  save-state register address.
REQ-012 sst_dato  out  8  save-state write data.
REQ-013 sst_we_reg  out  1  save-state register write strobe.
REQ-014 ss_rdat  in  8  save-state read data from sound unit, combinational from sst_addr.
REQ-015 busy  out  1  transfer in progress; done  out  1  one-cycle completion pulse; aborted  out  1  sticky, set when the last transfer ended by abort.

Function
REQ-016 States: IDLE, S_SETTLE, S_OUT, L_WAIT, L_WR, FINISH.
REQ-017 IDLE: cmd_save -> S_SETTLE; else cmd_load -> L_WAIT; cmd_save takes priority when both are high; on either, sst_addr <= ADDR_FIRST, sst_act <= 1, aborted <= 0.
REQ-018 cmd_save and cmd_load are ignored outside IDLE.
REQ-019 busy = 1 in every state except IDLE.
REQ-020 S_SETTLE lasts exactly one cycle: out_data <= ss_rdat, out_valid <= 1, -> S_OUT.
REQ-021 S_OUT: out_valid holds and out_data is stable until out_valid & out_ready.
REQ-022 On handshake in S_OUT: out_valid <= 0; if sst_addr == ADDR_LAST -> FINISH, else sst_addr + 1 -> S_SETTLE.
REQ-023 Save throughput: at most one byte per 2 cycles; byte count = ADDR_LAST - ADDR_FIRST + 1.
REQ-024 L_WAIT: in_ready = 1.
REQ-025 On in_valid & in_ready: sst_dato <= in_data, -> L_WR.
REQ-026 L_WR lasts one cycle with sst_we_reg = 1, sst_addr and sst_dato stable; then if sst_addr == ADDR_LAST -> FINISH, else sst_addr + 1 -> L_WAIT.
REQ-027 in_ready = 0 in every state except L_WAIT; sst_we_reg = 0 in every state except L_WR.
REQ-028 FINISH lasts one cycle: done = 1, sst_act <= 0, out_valid <= 0, -> IDLE.
REQ-029 sst_act stays 1 continuously from the cycle after command acceptance through FINISH, without gaps.
REQ-030 cmd_abort in any non-IDLE state -> FINISH next cycle and aborted <= 1.
REQ-031 cmd_abort coinciding with an S_OUT or L_WAIT handshake: the handshake completes and the next state is FINISH.
REQ-032 cmd_abort in L_WR: the write strobe completes and the next state is FINISH.
REQ-033 cmd_abort in IDLE is ignored.
REQ-034 sst_addr is 8 bits and never wraps: the sweep terminates at ADDR_LAST, including when ADDR_LAST = 255.
REQ-035 Single-address configuration (ADDR_FIRST = ADDR_LAST) transfers exactly one byte.
REQ-036 Addresses with no backing register (sound unit returns 8'hFF) are streamed like any other; the block does not filter them.

Reset
REQ-037 rst_n low forces, asynchronously: state IDLE, sst_act 0, sst_we_reg 0, sst_addr 0, sst_dato 0, out_data 0, out_valid 0, in_ready 0, busy 0, done 0, aborted 0.
REQ-038 Reset asserted mid-transfer drops sst_act and sst_we_reg immediately, with no done pulse.
REQ-039 After reset release, the block accepts a command on the first clock edge.

Verification
REQ-040 Save, default parameters, out_ready tied 1, model returns ss_rdat = sst_addr ^ 8'h5A -> 108 bytes, 0x4A..0x21 in order; busy for 217 cycles; one done pulse; aborted 0.
REQ-041 Load of 108 bytes 0x00..0x6B with in_valid gaps -> exactly 108 sst_we_reg pulses; pulse k at sst_addr 16+k with sst_dato k; sst_act continuous throughout.
REQ-042 Save with out_ready held low for 5 cycles at byte 3 -> out_data stable and out_valid high across the stall; no byte lost or duplicated.
REQ-043 cmd_abort on the same cycle as the 10th load handshake -> 10 writes total, FINISH next, done 1, aborted 1, in_ready 0.
REQ-044 cmd_save and cmd_load together in IDLE -> save performed; a cmd_load pulse during the save is ignored.
REQ-045 ADDR_FIRST = ADDR_LAST = 255, save -> one byte; sst_addr never reaches 0; then FINISH. rst_n pulsed low mid-load -> outputs at reset values that same cycle.
